// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Shares the memory bus between the CPU core and a DMA
//                requester. Arbitrates on every issue cycle (wait counter
//                idle), muxes address/size/write onto the bus, decodes the
//                region of the granted address into a wait-state count and
//                produces a single pause stream for memories and the CPU.
//
//  Ports       : clk, rst                  - bus clock, sync active-high reset
//                cpu_addr/wdata/size/write - CPU request (implicit, always on)
//                cpu_pause                 - CPU stall
//                dma_req/addr/wdata/size/write - DMA request
//                dma_gnt                   - DMA address accepted this cycle
//                dma_rvalid                - mem read data valid for last DMA read
//                mem_addr/wdata/size/write - muxed bus to memories
//                mem_pause                 - wait-state pause to memories
//                decode_err                - issued address is unmapped
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int EWRAM_WAIT    = 2,
    parameter int ROM_N_WAIT    = 4,
    parameter int ROM_S_WAIT    = 2,
    parameter int SRAM_WAIT     = 4,
    parameter int MAX_DMA_BURST = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_write,
    output logic        cpu_pause,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_size,
    input  logic        dma_write,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_write,
    output logic        mem_pause,
    output logic        decode_err
);

    localparam logic [7:0] c_EWRAM_WAIT = 8'(EWRAM_WAIT);
    localparam logic [7:0] c_ROM_N_WAIT = 8'(ROM_N_WAIT);
    localparam logic [7:0] c_ROM_S_WAIT = 8'(ROM_S_WAIT);
    localparam logic [7:0] c_SRAM_WAIT  = 8'(SRAM_WAIT);
    localparam logic [7:0] c_MAX_BURST  = 8'(MAX_DMA_BURST);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]  r_wait_cnt;
    logic [7:0]  r_burst_cnt;
    logic        r_owner;       // data-phase owner: 1 = DMA, 0 = CPU
    logic        r_rd_pend;     // previous issue was a DMA read
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_write;
    logic        r_rom_valid;
    logic [31:0] r_rom_addr;
    logic        r_rom_master;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic        w_issue;
    logic        w_dma_win;
    logic [31:0] w_addr;
    logic [1:0]  w_size;
    logic        w_write;

    assign w_issue   = (r_wait_cnt == 8'd0) && !rst;
    assign w_dma_win = dma_req && (r_burst_cnt < c_MAX_BURST);
    assign w_addr    = w_dma_win ? dma_addr  : cpu_addr;
    assign w_size    = w_dma_win ? dma_size  : cpu_size;
    assign w_write   = w_dma_win ? dma_write : cpu_write;

    // ------------------------------------------------------------------
    // Sequential ROM detection: same master, previous issue was ROM, and
    // the address steps by exactly the access size. Size 2'b11 has no
    // defined step, so it is never sequential.
    // ------------------------------------------------------------------
    logic [31:0] w_inc;
    logic        w_seq;

    always_comb begin
        w_inc = 32'd0;
        case (w_size)
            2'b00:   w_inc = 32'd1;
            2'b01:   w_inc = 32'd2;
            2'b10:   w_inc = 32'd4;
            default: w_inc = 32'd0;
        endcase
    end

    assign w_seq = r_rom_valid && (r_rom_master == w_dma_win) &&
                   (w_inc != 32'd0) && (w_addr == r_rom_addr + w_inc);

    // ------------------------------------------------------------------
    // Region decode -> wait states
    // ------------------------------------------------------------------
    logic [7:0] w_wait;
    logic       w_err;
    logic       w_is_rom;

    always_comb begin
        w_wait   = 8'd0;
        w_err    = 1'b0;
        w_is_rom = 1'b0;
        if (w_addr[31:28] != 4'h0) begin
            w_err = 1'b1;
        end else begin
            case (w_addr[27:24])
                4'h2: w_wait = c_EWRAM_WAIT;
                4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD: begin
                    w_is_rom = 1'b1;
                    w_wait   = w_seq ? c_ROM_S_WAIT : c_ROM_N_WAIT;
                end
                4'hE: w_wait = c_SRAM_WAIT;
                4'h1, 4'hF: w_err = 1'b1;
                default: w_wait = 8'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt   <= 8'd0;
            r_burst_cnt  <= 8'd0;
            r_owner      <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_addr       <= 32'd0;
            r_size       <= 2'b00;
            r_write      <= 1'b0;
            r_rom_valid  <= 1'b0;
            r_rom_addr   <= 32'd0;
            r_rom_master <= 1'b0;
        end else if (w_issue) begin
            r_wait_cnt  <= w_wait;
            r_burst_cnt <= w_dma_win ? r_burst_cnt + 8'd1 : 8'd0;
            r_owner     <= w_dma_win;
            r_rd_pend   <= w_dma_win && !dma_write;
            r_addr      <= w_addr;
            r_size      <= w_size;
            r_write     <= w_write;
            // Any non-ROM issue invalidates the stored ROM address; a
            // master change is caught by the master compare.
            r_rom_valid <= w_is_rom;
            if (w_is_rom) begin
                r_rom_addr   <= w_addr;
                r_rom_master <= w_dma_win;
            end
        end else begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: the bus shows the live granted request on issue cycles and
    // the held request otherwise; everything reads 0 while in reset.
    // ------------------------------------------------------------------
    assign mem_addr   = w_issue ? w_addr  : (rst ? 32'd0 : r_addr);
    assign mem_size   = w_issue ? w_size  : (rst ? 2'b00 : r_size);
    assign mem_write  = w_issue ? w_write : (!rst && r_write);
    assign mem_wdata  = rst ? 32'd0 : (r_owner ? dma_wdata : cpu_wdata);
    assign mem_pause  = !rst && (r_wait_cnt != 8'd0);
    assign dma_gnt    = w_issue && w_dma_win;
    assign cpu_pause  = mem_pause || dma_gnt;
    assign decode_err = w_issue && w_err;
    assign dma_rvalid = w_issue && r_rd_pend;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Scoreboard bench for mem_bus_arbiter. Stimulus pushes one
//                expected record per issue cycle; a negedge monitor pops a
//                record on every issue cycle and checks bus, grant, decode
//                error, read-valid and the length of the following pause.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr  = 32'h0300_0000;
    logic [31:0] cpu_wdata = 32'd0;
    logic [1:0]  cpu_size  = 2'b10;
    logic        cpu_write = 1'b0;
    logic        dma_req   = 1'b0;
    logic [31:0] dma_addr  = 32'd0;
    logic [31:0] dma_wdata = 32'd0;
    logic [1:0]  dma_size  = 2'b10;
    logic        dma_write = 1'b0;
    logic        cpu_pause, dma_gnt, dma_rvalid, mem_write, mem_pause, decode_err;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;

    mem_bus_arbiter #(
        .EWRAM_WAIT(2), .ROM_N_WAIT(4), .ROM_S_WAIT(2), .SRAM_WAIT(4),
        .MAX_DMA_BURST(2)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
        .cpu_write(cpu_write), .cpu_pause(cpu_pause),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_size(dma_size), .dma_write(dma_write), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_write(mem_write), .mem_pause(mem_pause), .decode_err(decode_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_dma;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          write;
        int          w;
        bit          err;
        bit          rv;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   have_cur = 1'b0;
    int   pause_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            chk("rst_ctl", {24'd0, mem_size, cpu_pause, dma_gnt, dma_rvalid,
                            mem_pause, decode_err, mem_write}, 32'd0);
            have_cur = 1'b0;
        end else if (!mem_pause) begin
            if (have_cur) chk("pause_len", pause_cnt, cur.w);
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_issue addr=%h at %0t", mem_addr, $time);
                have_cur = 1'b0;
            end else begin
                cur       = q.pop_front();
                have_cur  = 1'b1;
                pause_cnt = 0;
                chk("issue_addr", mem_addr, cur.addr);
                chk("issue_gnt", {31'd0, dma_gnt}, {31'd0, cur.is_dma});
                chk("issue_cpu_pause", {31'd0, cpu_pause}, {31'd0, cur.is_dma});
                chk("issue_size_write", {29'd0, mem_size, mem_write},
                    {29'd0, cur.size, cur.write});
                chk("issue_decode_err", {31'd0, decode_err}, {31'd0, cur.err});
                chk("issue_rvalid", {31'd0, dma_rvalid}, {31'd0, cur.rv});
            end
        end else begin
            pause_cnt++;
            if (have_cur) begin
                chk("wait_wdata", mem_wdata, cur.wdata);
                chk("wait_addr_hold", mem_addr, cur.addr);
                chk("wait_cpu_pause_gnt", {30'd0, cpu_pause, dma_gnt}, 32'd2);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic expect_issue(input bit d, input int w, input bit e, input bit rv);
        exp_t x;
        x.is_dma = d;
        x.addr   = d ? dma_addr  : cpu_addr;
        x.wdata  = d ? dma_wdata : cpu_wdata;
        x.size   = d ? dma_size  : cpu_size;
        x.write  = d ? dma_write : cpu_write;
        x.w      = w;
        x.err    = e;
        x.rv     = rv;
        q.push_back(x);
    endtask

    task automatic issue(input bit d, input int w, input bit e, input bit rv);
        expect_issue(d, w, e, rv);
        repeat (w + 1) @(posedge clk);
        #1;
    endtask

    task automatic cpu_rd(input logic [31:0] a, input logic [1:0] s);
        cpu_addr  = a;
        cpu_size  = s;
        cpu_write = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // IWRAM back-to-back, second with size code 3 passed through
        cpu_rd(32'h0300_0000, 2'b10); issue(0, 0, 0, 0);
        cpu_rd(32'h0300_0004, 2'b11); issue(0, 0, 0, 0);

        // ROM non-sequential, sequential, non-sequential, half sequential
        cpu_rd(32'h0800_0000, 2'b10); issue(0, 4, 0, 0);
        cpu_rd(32'h0800_0004, 2'b10); issue(0, 2, 0, 0);
        cpu_rd(32'h0800_0100, 2'b10); issue(0, 4, 0, 0);
        cpu_rd(32'h0800_0102, 2'b01); issue(0, 2, 0, 0);

        // Unmapped addresses
        cpu_rd(32'h1000_0000, 2'b10); issue(0, 0, 1, 0);
        cpu_rd(32'h0100_0000, 2'b10); issue(0, 0, 1, 0);

        // DMA EWRAM writes preempt the CPU; burst limit 2 forces a CPU slot
        cpu_rd(32'h0300_0008, 2'b10);
        cpu_wdata = 32'h0000_0011;
        dma_req = 1'b1; dma_write = 1'b1; dma_size = 2'b10;
        dma_addr = 32'h0200_0010; dma_wdata = 32'hA1A1_0001; issue(1, 2, 0, 0);
        dma_addr = 32'h0200_0014; dma_wdata = 32'hA2A2_0002; issue(1, 2, 0, 0);
        issue(0, 0, 0, 0);
        dma_addr = 32'h0200_0018; dma_wdata = 32'hA3A3_0003; issue(1, 2, 0, 0);

        // Clear the burst count, then starvation guard with W = 0 DMA reads
        dma_req = 1'b0; issue(0, 0, 0, 0);
        dma_req = 1'b1; dma_write = 1'b0; dma_addr = 32'h0300_0100;
        issue(1, 0, 0, 0);
        issue(1, 0, 0, 1);
        issue(0, 0, 0, 1);
        issue(1, 0, 0, 0);
        issue(1, 0, 0, 1);
        issue(0, 0, 0, 1);

        // ROM sequential tracking across master changes, byte step
        dma_req = 1'b0;
        cpu_rd(32'h0800_0200, 2'b10); issue(0, 4, 0, 0);
        dma_req = 1'b1; dma_addr = 32'h0800_0204; issue(1, 4, 0, 0);
        dma_addr = 32'h0800_0208; issue(1, 2, 0, 1);
        dma_req = 1'b0;
        cpu_rd(32'h0800_020C, 2'b10); issue(0, 4, 0, 1);
        cpu_rd(32'h0800_020D, 2'b00); issue(0, 2, 0, 0);

        // SRAM write, reset during the second wait cycle
        cpu_addr = 32'h0E00_0000; cpu_size = 2'b10; cpu_write = 1'b1;
        cpu_wdata = 32'hCAFE_0000;
        expect_issue(0, 4, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        dma_req = 1'b1; dma_addr = 32'h0300_0200; dma_write = 1'b0;
        cpu_rd(32'h0300_0000, 2'b10);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        issue(1, 0, 0, 0);
        dma_req = 1'b0;
        issue(0, 0, 0, 1);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the simulation memory bus (system ROM, RAMs, GamePak ROM/SRAM) between the ARM7TDMI-S core and a DMA requester. Also generates per-region wait states as a single `pause` stream. It sits between the two bus masters and the memory models. It owns the arbitration decision, drives the muxed address, write-data, size and write lines, and produces the pause seen by memories and by the CPU. This replaces the ad-hoc pause generation in the memory testbench.

## Interface
Parameters:
- `EWRAM_WAIT`, default 2: wait states for region 0x2.
- `ROM_N_WAIT`, default 4: non-sequential GamePak ROM wait states (regions 0x8–0xD).
- `ROM_S_WAIT`, default 2: sequential GamePak ROM wait states.
- `SRAM_WAIT`, default 4: wait states for region 0xE.
- `MAX_DMA_BURST`, default 8: consecutive DMA grants before one CPU slot is forced. Legal range 1..255.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: bus clock.
- `rst` in 1: synchronous, active-high reset.
- `cpu_addr` in 32: CPU address.
- `cpu_wdata` in 32: CPU write data.
- `cpu_size` in 2: CPU access size.
- `cpu_write` in 1: CPU write request.
- `cpu_pause` out 1: CPU stall (core PAUSE input).
- `dma_req` in 1: DMA wants an access (level).
- `dma_addr` in 32: DMA address.
- `dma_wdata` in 32: DMA write data.
- `dma_size` in 2: DMA access size.
- `dma_write` in 1: DMA write request.
- `dma_gnt` out 1: pulse, DMA address accepted this cycle.
- `dma_rvalid` out 1: pulse, `mem_rdata` valid for the DMA's last read.
- `mem_addr` out 32: muxed address to memories.
- `mem_wdata` out 32: data-phase write data.
- `mem_size` out 2: muxed access size.
- `mem_write` out 1: muxed write request.
- `mem_pause` out 1: wait-state pause to all memories.
- `decode_err` out 1: pulse, issued address is unmapped.

## Operation
- **Issue cycle.** Any cycle with `wait_cnt == 0` and `rst` low is an issue cycle. Exactly one master's address is presented on `mem_*` in that cycle.
- **Grant on an issue cycle.**
  - DMA wins if `dma_req` = 1 and `burst_cnt < MAX_DMA_BURST`; otherwise the CPU wins. The CPU always has an implicit request.
  - A DMA grant asserts `dma_gnt` and `cpu_pause` and increments `burst_cnt`.
  - A CPU grant clears `burst_cnt` to 0.
  - If `burst_cnt == MAX_DMA_BURST` while `dma_req` = 1, the CPU takes the slot and `burst_cnt` clears.
- **Non-issue cycles.** `mem_addr`, `mem_size` and `mem_write` hold the values of the last issue cycle. `dma_gnt` = 0.
- **Region decode** on the granted address:
  - If `addr[31:28] != 0`: W = 0 and `decode_err` pulses.
  - Otherwise decode `addr[27:24]`:
    - 0x2 → `EWRAM_WAIT`.
    - 0x8–0xD → `ROM_S_WAIT` if sequential, else `ROM_N_WAIT`.
    - 0xE → `SRAM_WAIT`.
    - 0x0, 0x3–0x7 → 0.
    - 0x1, 0xF → 0 and `decode_err` pulses.
- **Sequential ROM access** requires all of the following:
  - same master as the previous ROM access;
  - previous access was also a ROM access;
  - `addr` == previous ROM address + (2 for half, 4 for word, 1 for byte).
  - Any non-ROM issue, or a master change, invalidates the stored ROM address.
- **Wait counter.** On an issue cycle, `wait_cnt` loads W at the clock edge. It decrements by 1 each cycle while non-zero.
- **Pause outputs.**
  - `mem_pause = (wait_cnt != 0)`.
  - `cpu_pause = mem_pause | (issue cycle && DMA granted)`.
- **Data-phase owner register.** It records the master of each issue cycle and drives `mem_wdata` from that master's wdata. It holds until the next issue cycle.
- **`dma_rvalid`.** Asserted in the first issue cycle following a DMA read's issue cycle (cycle t+W+1).
- **Size code.** A size code of 2'b11 on the granted master is passed through unchanged. The bus monitor flags it.

## Timing
- **Access at cycle t with W wait states:**
  - `mem_pause` = 1 for cycles t+1..t+W.
  - The next issue is at cycle t+W+1.
  - W = 0 gives back-to-back issues every cycle.
- **Read data and write data.** Read data from the memory registered at the edge ending t is valid for t+1..t+W+1. `mem_wdata` for that access is valid over the same window.
- **Reset (synchronous, `rst` = 1 at a rising edge) clears:**
  - `wait_cnt`, `burst_cnt`, the owner register (→CPU), the ROM-sequential valid bit, and `dma_rvalid`.
  - Every output is 0 while `rst` = 1.
  - `mem_addr`, `mem_size`, `mem_write` and `mem_wdata` reset to 0.
- **Reset mid-wait** aborts the access. The first cycle after `rst` drops is an issue cycle. A pending DMA is re-arbitrated.
- **`dma_req` dropping** during a DMA access's wait cycles does not cancel that access. It only affects the next issue cycle.
- **`dma_req` rising** mid-wait takes effect at the next issue cycle only.

## Test plan
- **IWRAM back-to-back.** CPU reads 0x0300_0000, 0x0300_0004 with no DMA → `mem_pause` never asserts; two issue cycles in consecutive cycles.
- **ROM non-sequential then sequential.** CPU word reads 0x0800_0000 then 0x0800_0004 → `mem_pause` high 4 cycles, then 2 cycles. Next read 0x0800_0100 → 4 cycles again.
- **DMA preempts CPU.** `dma_req` = 1 over 3 EWRAM writes at 0x0200_0010.. → 3 `dma_gnt` pulses 3 cycles apart; `cpu_pause` high throughout; `mem_wdata` equals `dma_wdata` in each data phase.
- **Starvation guard.** `MAX_DMA_BURST` = 2, `dma_req` held with W = 0 → grants repeat DMA, DMA, CPU, DMA, DMA, CPU.
- **Unmapped address.** CPU issues 0x1000_0000 → `decode_err` pulses for one cycle; W = 0.
- **Reset mid-wait.** `rst` asserted during SRAM wait cycle 2 → next cycle all outputs 0; after release, `wait_cnt` = 0 and a new issue occurs immediately.
